// File: rtl/axi4_lite_master_if.sv
// axi4_lite_master_if: command/response port and AXI4-Lite bus of axi4_lite_master
interface axi4_lite_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_SIZE  = 32
);
  logic                   cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [ADDR_WIDTH-1:0]  cmd_addr_i;
  logic [DATA_SIZE-1:0]   cmd_wdata_i;
  logic [DATA_SIZE/8-1:0] cmd_wstrb_i;
  logic                   rsp_valid_o, rsp_ready_i, rsp_write_o;
  logic [DATA_SIZE-1:0]   rsp_rdata_o;
  logic [1:0]             rsp_resp_o;
  logic [ADDR_WIDTH-1:0]  awaddr_o;
  logic [2:0]             awprot_o;
  logic                   awvalid_o, awready_i;
  logic [DATA_SIZE-1:0]   wdata_o;
  logic [DATA_SIZE/8-1:0] wstrb_o;
  logic                   wvalid_o, wready_i;
  logic [1:0]             bresp_i;
  logic                   bvalid_i, bready_o;
  logic [ADDR_WIDTH-1:0]  araddr_o;
  logic [2:0]             arprot_o;
  logic                   arvalid_o, arready_i;
  logic [DATA_SIZE-1:0]   rdata_i;
  logic [1:0]             rresp_i;
  logic                   rvalid_i, rready_o;
  modport master (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_wstrb_i, rsp_ready_i,
    output cmd_ready_o, rsp_valid_o, rsp_write_o, rsp_rdata_o, rsp_resp_o,
    output awaddr_o, awprot_o, awvalid_o, input awready_i,
    output wdata_o, wstrb_o, wvalid_o, input wready_i,
    input  bresp_i, bvalid_i, output bready_o,
    output araddr_o, arprot_o, arvalid_o, input arready_i,
    input  rdata_i, rresp_i, rvalid_i, output rready_o
  );
  modport slave (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_wstrb_i, rsp_ready_i,
    input  cmd_ready_o, rsp_valid_o, rsp_write_o, rsp_rdata_o, rsp_resp_o,
    input  awaddr_o, awprot_o, awvalid_o, output awready_i,
    input  wdata_o, wstrb_o, wvalid_o, output wready_i,
    output bresp_i, bvalid_i, input bready_o,
    input  araddr_o, arprot_o, arvalid_o, output arready_i,
    output rdata_i, rresp_i, rvalid_i, input rready_o
  );
endinterface

// File: rtl/axi4_lite_master.sv
// axi4_lite_master: one-at-a-time command to AXI4-Lite bridge; AXI4_LITE_MASTER_STATS_EN adds counters
module axi4_lite_master #(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_SIZE  = 32,
  parameter logic [2:0] PROT       = 3'b000
) (
  input logic clk_i,
  input logic rst_clk_ni,
  axi4_lite_master_if.master bus
`ifdef AXI4_LITE_MASTER_STATS_EN
  ,
  output logic [15:0] wr_count_o,
  output logic [15:0] rd_count_o,
  output logic [15:0] err_count_o
`endif
);
  localparam int STRB = DATA_SIZE / 8;
  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP} state_e;
  state_e                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d, awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic                  bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
  logic                  rsp_valid_q, rsp_valid_d, write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_SIZE-1:0]  wdata_q, wdata_d, rdata_q, rdata_d;
  logic [STRB-1:0]       wstrb_q, wstrb_d;
  logic [1:0]            resp_q, resp_d;
  // Next state and next value of every registered output
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rdata_d     = rdata_q;
    resp_d      = resp_q;
    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid_i && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          write_d     = bus.cmd_write_i;
          addr_d      = bus.cmd_addr_i;
          wdata_d     = bus.cmd_wdata_i;
          wstrb_d     = bus.cmd_wstrb_i;
          awvalid_d   = bus.cmd_write_i;
          wvalid_d    = bus.cmd_write_i;
          arvalid_d   = !bus.cmd_write_i;
          state_d     = bus.cmd_write_i ? WR : RD_ADDR;
        end
      end
      WR: begin
        awvalid_d = awvalid_q && !bus.awready_i;
        wvalid_d  = wvalid_q && !bus.wready_i;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bus.bvalid_i && bready_q) begin
          bready_d    = 1'b0;
          resp_d      = bus.bresp_i;
          rdata_d     = '0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RD_ADDR: begin
        if (bus.arready_i && arvalid_q) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (bus.rvalid_i && rready_q) begin
          rready_d    = 1'b0;
          resp_d      = bus.rresp_i;
          rdata_d     = bus.rdata_i;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (bus.rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // State and output registers; reset drops every valid/ready at once
  always_ff @(posedge clk_i or negedge rst_clk_ni) begin
    if (!rst_clk_ni) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
    end
  end
  assign bus.cmd_ready_o = cmd_ready_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_write_o = write_q;
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.rsp_resp_o  = resp_q;
  assign bus.awaddr_o    = addr_q;
  assign bus.awprot_o    = PROT;
  assign bus.awvalid_o   = awvalid_q;
  assign bus.wdata_o     = wdata_q;
  assign bus.wstrb_o     = wstrb_q;
  assign bus.wvalid_o    = wvalid_q;
  assign bus.bready_o    = bready_q;
  assign bus.araddr_o    = addr_q;
  assign bus.arprot_o    = PROT;
  assign bus.arvalid_o   = arvalid_q;
  assign bus.rready_o    = rready_q;
`ifdef AXI4_LITE_MASTER_STATS_EN
  logic [15:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, err_cnt_q, err_cnt_d;
  logic        rsp_fire;
  // Saturating counts of completed writes, reads and error responses
  always_comb begin
    rsp_fire  = rsp_valid_q && bus.rsp_ready_i;
    wr_cnt_d  = (rsp_fire && write_q && wr_cnt_q != 16'hFFFF) ? wr_cnt_q + 16'd1 : wr_cnt_q;
    rd_cnt_d  = (rsp_fire && !write_q && rd_cnt_q != 16'hFFFF) ? rd_cnt_q + 16'd1 : rd_cnt_q;
    err_cnt_d = (rsp_fire && resp_q[1] && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
  end
  // Counter registers
  always_ff @(posedge clk_i or negedge rst_clk_ni) begin
    if (!rst_clk_ni) begin
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end
  assign wr_count_o  = wr_cnt_q;
  assign rd_count_o  = rd_cnt_q;
  assign err_count_o = err_cnt_q;
`endif
endmodule

// File: tb/tb_axi4_lite_master.sv
// tb_axi4_lite_master: randomized bench for axi4_lite_master against a register-slave reference model
module tb_axi4_lite_master;
  logic clk_i = 1'b0;
  logic rst_clk_ni = 1'b0;
  always #5 clk_i = ~clk_i;
  axi4_lite_master_if #(.ADDR_WIDTH(32), .DATA_SIZE(32)) bus ();
`ifdef AXI4_LITE_MASTER_STATS_EN
  logic [15:0] wr_count, rd_count, err_count;
`endif
  axi4_lite_master #(.ADDR_WIDTH(32), .DATA_SIZE(32), .PROT(3'b000)) dut (
    .clk_i(clk_i),
    .rst_clk_ni(rst_clk_ni),
    .bus(bus)
`ifdef AXI4_LITE_MASTER_STATS_EN
    ,
    .wr_count_o(wr_count),
    .rd_count_o(rd_count),
    .err_count_o(err_count)
`endif
  );
  int checks = 0;
  int errors = 0;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Slave address map: above 0x3F decodes nowhere, word 0x3C is a faulting register
  function automatic logic [1:0] resp_of(input logic [31:0] a);
    return (a[31:6] != 0) ? 2'b11 : (a[5:2] == 4'hF) ? 2'b10 : 2'b00;
  endfunction
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [31:0] smem [16];
  logic [31:0] ref_mem [16];
  int exp_wr = 0, exp_rd = 0, exp_err = 0;
  // Register slave with programmable wait states, plus channel protocol checks
  initial begin
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic aw_got, w_got, ar_got, bpend, rpend;
    logic p_aw_v, p_aw_r, p_w_v, p_w_r, p_ar_v, p_ar_r, p_b, p_r, p_bready;
    logic [31:0] aw_a, w_d, ar_a, p_aw_a, p_w_d, p_ar_a;
    logic [3:0] w_s, p_w_s;
    logic [1:0] r;
    for (int i = 0; i < 16; i++) smem[i] = '0;
    bus.awready_i = 0; bus.wready_i = 0; bus.bvalid_i = 0; bus.bresp_i = 0;
    bus.arready_i = 0; bus.rvalid_i = 0; bus.rdata_i = 0; bus.rresp_i = 0;
    {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt} = '0;
    {aw_got, w_got, ar_got, bpend, rpend} = '0;
    {p_aw_v, p_aw_r, p_w_v, p_w_r, p_ar_v, p_ar_r, p_b, p_r, p_bready} = '0;
    {aw_a, w_d, ar_a, p_aw_a, p_w_d, p_ar_a, w_s, p_w_s} = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_clk_ni) begin
        bus.awready_i = 0; bus.wready_i = 0; bus.bvalid_i = 0; bus.arready_i = 0; bus.rvalid_i = 0;
        {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt} = '0;
        {aw_got, w_got, ar_got, bpend, rpend} = '0;
        {p_aw_v, p_aw_r, p_w_v, p_w_r, p_ar_v, p_ar_r, p_b, p_r, p_bready} = '0;
      end else begin
        if (p_aw_v) begin
          if (p_aw_r) check("awvalid_drop", bus.awvalid_o, 0);
          else check("aw_hold", {bus.awvalid_o, bus.awaddr_o}, {1'b1, p_aw_a});
        end
        if (p_w_v) begin
          if (p_w_r) check("wvalid_drop", bus.wvalid_o, 0);
          else check("w_hold", {bus.wvalid_o, bus.wdata_o, bus.wstrb_o}, {1'b1, p_w_d, p_w_s});
        end
        if (p_ar_v) begin
          if (p_ar_r) check("arvalid_drop", bus.arvalid_o, 0);
          else check("ar_hold", {bus.arvalid_o, bus.araddr_o}, {1'b1, p_ar_a});
        end
        if (p_b) check("bready_drop", bus.bready_o, 0);
        if (p_r) check("rready_drop", bus.rready_o, 0);
        if (bpend) begin bus.bvalid_i = 0; bpend = 0; aw_got = 0; w_got = 0; end
        if (bus.awready_i) begin bus.awready_i = 0; aw_got = 1; end
        else if (bus.awvalid_o && !aw_got) begin
          if (aw_cnt >= aw_dly) begin bus.awready_i = 1; aw_a = bus.awaddr_o; aw_cnt = 0; end
          else aw_cnt++;
        end
        if (bus.wready_i) begin bus.wready_i = 0; w_got = 1; end
        else if (bus.wvalid_o && !w_got) begin
          if (w_cnt >= w_dly) begin bus.wready_i = 1; w_d = bus.wdata_o; w_s = bus.wstrb_o; w_cnt = 0; end
          else w_cnt++;
        end
        if (bus.bready_o && !p_bready) check("bready_after_aw_w", {aw_got, w_got}, 2'b11);
        if (aw_got && w_got && !bus.bvalid_i) begin
          if (b_cnt >= b_dly) begin
            b_cnt = 0;
            r = resp_of(aw_a);
            if (r == 2'b00)
              for (int b = 0; b < 4; b++) if (w_s[b]) smem[aw_a[5:2]][8*b +: 8] = w_d[8*b +: 8];
            bus.bresp_i = r;
            bus.bvalid_i = 1;
          end else b_cnt++;
        end
        if (bus.bvalid_i && bus.bready_o) bpend = 1;
        if (rpend) begin bus.rvalid_i = 0; rpend = 0; ar_got = 0; end
        if (bus.arready_i) begin bus.arready_i = 0; ar_got = 1; end
        else if (bus.arvalid_o && !ar_got) begin
          if (ar_cnt >= ar_dly) begin bus.arready_i = 1; ar_a = bus.araddr_o; ar_cnt = 0; end
          else ar_cnt++;
        end
        if (ar_got && !bus.rvalid_i) begin
          if (r_cnt >= r_dly) begin
            r_cnt = 0;
            r = resp_of(ar_a);
            bus.rresp_i = r;
            bus.rdata_i = (r == 2'b00) ? smem[ar_a[5:2]] : 32'h0;
            bus.rvalid_i = 1;
          end else r_cnt++;
        end
        if (bus.rvalid_i && bus.rready_o) rpend = 1;
        p_aw_v = bus.awvalid_o; p_aw_r = bus.awready_i; p_aw_a = bus.awaddr_o;
        p_w_v = bus.wvalid_o; p_w_r = bus.wready_i; p_w_d = bus.wdata_o; p_w_s = bus.wstrb_o;
        p_ar_v = bus.arvalid_o; p_ar_r = bus.arready_i; p_ar_a = bus.araddr_o;
        p_b = bus.bvalid_i && bus.bready_o;
        p_r = bus.rvalid_i && bus.rready_o;
        p_bready = bus.bready_o;
      end
    end
  end
  // One command through the bridge, checked against the reference register model
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input int hold, input bit chk_lat);
    int n, lat;
    logic [1:0] er;
    logic [31:0] ed;
    er = resp_of(a);
    ed = '0;
    if (wr) begin
      if (er == 2'b00) for (int b = 0; b < 4; b++) if (s[b]) ref_mem[a[5:2]][8*b +: 8] = d[8*b +: 8];
    end else if (er == 2'b00) ed = ref_mem[a[5:2]];
    @(negedge clk_i);
    bus.cmd_valid_i = 1; bus.cmd_write_i = wr; bus.cmd_addr_i = a; bus.cmd_wdata_i = d; bus.cmd_wstrb_i = s;
    n = 0;
    while (!bus.cmd_ready_o && n < 50) begin @(negedge clk_i); n++; end
    if (n >= 50) begin check("cmd_accept_timeout", 0, 1); bus.cmd_valid_i = 0; return; end
    @(negedge clk_i);
    bus.cmd_valid_i = 0;
    bus.cmd_write_i = 1'($urandom); bus.cmd_addr_i = $urandom; bus.cmd_wdata_i = $urandom; bus.cmd_wstrb_i = 4'($urandom);
    check("cmd_ready_busy", bus.cmd_ready_o, 0);
    if (wr) check("write_issue", {bus.awvalid_o, bus.wvalid_o, bus.arvalid_o, bus.awprot_o, bus.awaddr_o, bus.wdata_o, bus.wstrb_o},
                  {3'b110, 3'b000, a, d, s});
    else check("read_issue", {bus.arvalid_o, bus.awvalid_o, bus.wvalid_o, bus.arprot_o, bus.araddr_o}, {3'b100, 3'b000, a});
    lat = 1;
    n = 0;
    while (!bus.rsp_valid_o && n < 200) begin @(negedge clk_i); lat++; n++; end
    if (n >= 200) begin check("rsp_timeout", 0, 1); return; end
    if (chk_lat) check("rsp_latency", lat, 3);
    check("rsp_fields", {bus.rsp_write_o, bus.rsp_resp_o, bus.rsp_rdata_o}, {wr, er, ed});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      check("rsp_hold", {bus.cmd_ready_o, bus.rsp_valid_o, bus.rsp_write_o, bus.rsp_resp_o, bus.rsp_rdata_o},
            {2'b01, wr, er, ed});
    end
    bus.rsp_ready_i = 1;
    @(negedge clk_i);
    bus.rsp_ready_i = 0;
    check("rsp_done", {bus.rsp_valid_o, bus.cmd_ready_o}, 2'b01);
    if (wr) exp_wr++; else exp_rd++;
    if (er[1]) exp_err++;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int n;
    logic wr;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    bus.cmd_valid_i = 0; bus.cmd_write_i = 0; bus.cmd_addr_i = 0; bus.cmd_wdata_i = 0; bus.cmd_wstrb_i = 0;
    bus.rsp_ready_i = 0;
    repeat (2) @(negedge clk_i);
    check("reset_ctrl", {bus.cmd_ready_o, bus.rsp_valid_o, bus.awvalid_o, bus.wvalid_o, bus.bready_o, bus.arvalid_o, bus.rready_o}, 0);
    check("reset_bus", {bus.awaddr_o, bus.araddr_o, bus.wdata_o, bus.wstrb_o}, 0);
    check("reset_rsp", {bus.rsp_rdata_o, bus.rsp_resp_o, bus.rsp_write_o}, 0);
    rst_clk_ni = 1;
    @(negedge clk_i);
    check("ready_after_reset", bus.cmd_ready_o, 1);
    issue(1, 32'h4, 32'hDEADBEEF, 4'hF, 0, 1);
    issue(0, 32'h4, 32'h0, 4'h0, 0, 1);
    w_dly = 5;
    issue(1, 32'h8, 32'h12345678, 4'b0101, 1, 0);
    w_dly = 0;
    issue(0, 32'h8, 32'h0, 4'h0, 0, 1);
    r_dly = 1;
    issue(0, 32'h3C, 32'h0, 4'h0, 4, 0);
    r_dly = 0;
    ar_dly = 20;
    @(negedge clk_i);
    bus.cmd_valid_i = 1; bus.cmd_write_i = 0; bus.cmd_addr_i = 32'h10;
    n = 0;
    while (!bus.arvalid_o && n < 20) begin @(negedge clk_i); n++; end
    bus.cmd_valid_i = 0;
    check("ar_pending", bus.arvalid_o, 1);
    #2 rst_clk_ni = 0;
    #1 check("reset_async", {bus.arvalid_o, bus.cmd_ready_o, bus.rsp_valid_o}, 0);
    @(negedge clk_i);
    check("reset_held", {bus.arvalid_o, bus.cmd_ready_o, bus.rready_o}, 0);
    ar_dly = 0;
    @(negedge clk_i);
    rst_clk_ni = 1;
    @(negedge clk_i);
    check("ready_after_release", bus.cmd_ready_o, 1);
    issue(0, 32'h4, 32'h0, 4'h0, 0, 1);
    for (int t = 0; t < 40; t++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      if (t % 4 == 0) begin aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; end
      wr = 1'($urandom);
      issue(wr, {26'($urandom_range(0, 19)), 2'b00} << 0, $urandom, 4'($urandom), $urandom_range(0, 3),
            (aw_dly + w_dly + b_dly + ar_dly + r_dly) == 0);
    end
`ifdef AXI4_LITE_MASTER_STATS_EN
    check("wr_count", wr_count, exp_wr);
    check("rd_count", rd_count, exp_rd);
    check("err_count", err_count, exp_err);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
